// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID, ID/EX and EX/MEM registers driven by the hazard unit's enables,
// with saturating stall/flush counters and a sticky enable-mismatch flag.
module hazard_pipe_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PC_Wr,
    input  logic             IFID_Wr,
    input  logic             ctrl_Wr,
    input  logic             flush_IFID,
    input  logic [31:0]      pc_next,
    input  logic [31:0]      instr_IF,
    input  logic             RegWr_ID,
    input  logic             MemtoReg_ID,
    input  logic             MemWr_ID,
    input  logic [2:0]       ALUctr_ID,
    input  logic [4:0]       rw_ID,
    input  logic [31:0]      busA_ID,
    input  logic [31:0]      busB_ID,
    input  logic [31:0]      imm_ID,
    input  logic [31:0]      alu_result_Ex,
    output logic [31:0]      PC,
    output logic [31:0]      instr_IFID,
    output logic [31:0]      pcplus4_IFID,
    output logic [4:0]       rs_IFID,
    output logic [4:0]       rt_IFID,
    output logic             RegWr_IDEx,
    output logic             MemtoReg_IDEx,
    output logic             MemWr_IDEx,
    output logic [2:0]       ALUctr_IDEx,
    output logic [4:0]       rt_IDEx,
    output logic [4:0]       rw_Ex,
    output logic [31:0]      busA_IDEx,
    output logic [31:0]      busB_IDEx,
    output logic [31:0]      imm_IDEx,
    output logic             RegWr_ExMem,
    output logic             MemtoReg_ExMem,
    output logic             MemWr_ExMem,
    output logic [4:0]       rw_ExMem,
    output logic [31:0]      alu_ExMem,
    output logic [31:0]      busB_ExMem,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             en_err
);

    typedef struct packed {
        logic       reg_wr;
        logic       memto_reg;
        logic       mem_wr;
        logic [2:0] alu_ctr;
    } ctrl_t;

    ctrl_t ctrl_id, ctrl_idex;
    logic  stall_evt, flush_evt, en_mismatch;

    // A deasserted ctrl_Wr turns the ID controls into a bubble.
    always_comb begin
        ctrl_id = '0;
        if (ctrl_Wr)
            ctrl_id = '{reg_wr: RegWr_ID, memto_reg: MemtoReg_ID,
                        mem_wr: MemWr_ID, alu_ctr: ALUctr_ID};
    end

    assign rs_IFID       = instr_IFID[25:21];
    assign rt_IFID       = instr_IFID[20:16];
    assign RegWr_IDEx    = ctrl_idex.reg_wr;
    assign MemtoReg_IDEx = ctrl_idex.memto_reg;
    assign MemWr_IDEx    = ctrl_idex.mem_wr;
    assign ALUctr_IDEx   = ctrl_idex.alu_ctr;

    assign stall_evt   = ~ctrl_Wr;
    assign flush_evt   = flush_IFID & IFID_Wr;
    assign en_mismatch = (PC_Wr != IFID_Wr) || (IFID_Wr != ctrl_Wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= RESET_PC;
            instr_IFID   <= '0;
            pcplus4_IFID <= '0;
        end else begin
            if (PC_Wr)
                PC <= pc_next;
            // A held IF/ID also swallows any flush in the same cycle.
            if (IFID_Wr) begin
                instr_IFID   <= flush_IFID ? 32'h0 : instr_IF;
                pcplus4_IFID <= PC + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_idex <= '0;
            rt_IDEx   <= '0;
            rw_Ex     <= '0;
            busA_IDEx <= '0;
            busB_IDEx <= '0;
            imm_IDEx  <= '0;
        end else begin
            ctrl_idex <= ctrl_id;
            rt_IDEx   <= rt_IFID;
            rw_Ex     <= rw_ID;
            busA_IDEx <= busA_ID;
            busB_IDEx <= busB_ID;
            imm_IDEx  <= imm_ID;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWr_ExMem    <= 1'b0;
            MemtoReg_ExMem <= 1'b0;
            MemWr_ExMem    <= 1'b0;
            rw_ExMem       <= '0;
            alu_ExMem      <= '0;
            busB_ExMem     <= '0;
        end else begin
            RegWr_ExMem    <= ctrl_idex.reg_wr;
            MemtoReg_ExMem <= ctrl_idex.memto_reg;
            MemWr_ExMem    <= ctrl_idex.mem_wr;
            rw_ExMem       <= rw_Ex;
            alu_ExMem      <= alu_result_Ex;
            busB_ExMem     <= busB_IDEx;
        end
    end

    // Clear wins over counting; a mismatch in the clear cycle still sets the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            en_err    <= 1'b0;
        end else begin
            if (cnt_clr) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (stall_evt && stall_cnt != '1)
                    stall_cnt <= stall_cnt + 1'b1;
                if (flush_evt && flush_cnt != '1)
                    flush_cnt <= flush_cnt + 1'b1;
            end
            if (en_mismatch)
                en_err <= 1'b1;
            else if (cnt_clr)
                en_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// Directed bench for hazard_pipe_regs: reset, free run, load-use stall,
// flush, counter saturation/clear, enable-mismatch flag, PC wrap, async reset.
module tb_hazard_pipe_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PC_Wr, IFID_Wr, ctrl_Wr, flush_IFID;
    logic [31:0] pc_next, instr_IF;
    logic        RegWr_ID, MemtoReg_ID, MemWr_ID;
    logic [2:0]  ALUctr_ID;
    logic [4:0]  rw_ID;
    logic [31:0] busA_ID, busB_ID, imm_ID, alu_result_Ex;
    logic [31:0] PC, instr_IFID, pcplus4_IFID;
    logic [4:0]  rs_IFID, rt_IFID;
    logic        RegWr_IDEx, MemtoReg_IDEx, MemWr_IDEx;
    logic [2:0]  ALUctr_IDEx;
    logic [4:0]  rt_IDEx, rw_Ex;
    logic [31:0] busA_IDEx, busB_IDEx, imm_IDEx;
    logic        RegWr_ExMem, MemtoReg_ExMem, MemWr_ExMem;
    logic [4:0]  rw_ExMem;
    logic [31:0] alu_ExMem, busB_ExMem;
    logic        cnt_clr;
    logic [3:0]  stall_cnt, flush_cnt;
    logic        en_err;

    int errs = 0;
    int checks = 0;

    hazard_pipe_regs #(.RESET_PC(32'h0000_3000), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .PC_Wr(PC_Wr), .IFID_Wr(IFID_Wr), .ctrl_Wr(ctrl_Wr), .flush_IFID(flush_IFID),
        .pc_next(pc_next), .instr_IF(instr_IF),
        .RegWr_ID(RegWr_ID), .MemtoReg_ID(MemtoReg_ID), .MemWr_ID(MemWr_ID),
        .ALUctr_ID(ALUctr_ID), .rw_ID(rw_ID),
        .busA_ID(busA_ID), .busB_ID(busB_ID), .imm_ID(imm_ID),
        .alu_result_Ex(alu_result_Ex),
        .PC(PC), .instr_IFID(instr_IFID), .pcplus4_IFID(pcplus4_IFID),
        .rs_IFID(rs_IFID), .rt_IFID(rt_IFID),
        .RegWr_IDEx(RegWr_IDEx), .MemtoReg_IDEx(MemtoReg_IDEx), .MemWr_IDEx(MemWr_IDEx),
        .ALUctr_IDEx(ALUctr_IDEx), .rt_IDEx(rt_IDEx), .rw_Ex(rw_Ex),
        .busA_IDEx(busA_IDEx), .busB_IDEx(busB_IDEx), .imm_IDEx(imm_IDEx),
        .RegWr_ExMem(RegWr_ExMem), .MemtoReg_ExMem(MemtoReg_ExMem), .MemWr_ExMem(MemWr_ExMem),
        .rw_ExMem(rw_ExMem), .alu_ExMem(alu_ExMem), .busB_ExMem(busB_ExMem),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .en_err(en_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic en(input logic p, input logic i, input logic c);
        PC_Wr = p; IFID_Wr = i; ctrl_Wr = c;
    endtask

    initial begin
        rst_n = 1'b0; en(1, 1, 1); flush_IFID = 0; cnt_clr = 0;
        pc_next = 0; instr_IF = 0; RegWr_ID = 0; MemtoReg_ID = 0; MemWr_ID = 0;
        ALUctr_ID = 0; rw_ID = 0; busA_ID = 0; busB_ID = 0; imm_ID = 0; alu_result_Ex = 0;
        #12;
        chk("rst_pc", PC, 32'h3000);
        chk("rst_instr", instr_IFID, 0);
        chk("rst_ctrl", {RegWr_IDEx, MemtoReg_IDEx, MemWr_IDEx, RegWr_ExMem, MemtoReg_ExMem}, 0);
        chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
        chk("rst_err", en_err, 0);
        rst_n = 1'b1;

        // Free run: lw r2,4(r1) fetched
        pc_next = 32'h3004; instr_IF = 32'h8C22_0004;
        tick();
        chk("fr_pc", PC, 32'h3004);
        chk("fr_instr", instr_IFID, 32'h8C22_0004);
        chk("fr_rs", rs_IFID, 1);
        chk("fr_rt", rt_IFID, 2);
        chk("fr_pc4", pcplus4_IFID, 32'h3004);

        // lw decoded in ID; dependent add fetched
        pc_next = 32'h3008; instr_IF = 32'h0043_0820;
        RegWr_ID = 1; MemtoReg_ID = 1; ALUctr_ID = 3'b010; rw_ID = 2;
        busA_ID = 32'h100; busB_ID = 32'h55; imm_ID = 4;
        tick();
        chk("lw_memtoreg_idex", MemtoReg_IDEx, 1);
        chk("lw_rw_ex", rw_Ex, 2);
        chk("lw_rt_idex", rt_IDEx, 2);
        chk("lw_alu_idex", ALUctr_IDEx, 3'b010);
        chk("lw_busa_idex", busA_IDEx, 32'h100);
        chk("lw_pc4", pcplus4_IFID, 32'h3008);

        // One-cycle load-use stall
        en(0, 0, 0); pc_next = 32'h300C; instr_IF = 32'hDEAD_BEEF;
        MemtoReg_ID = 0; rw_ID = 1; alu_result_Ex = 32'h104;
        tick();
        chk("st_pc_hold", PC, 32'h3008);
        chk("st_instr_hold", instr_IFID, 32'h0043_0820);
        chk("st_bubble", {RegWr_IDEx, MemtoReg_IDEx, MemWr_IDEx, ALUctr_IDEx}, 0);
        chk("st_rw_ex", rw_Ex, 1);
        chk("st_memtoreg_exmem", MemtoReg_ExMem, 1);
        chk("st_rw_exmem", rw_ExMem, 2);
        chk("st_alu_exmem", alu_ExMem, 32'h104);
        chk("st_busb_exmem", busB_ExMem, 32'h55);
        chk("st_cnt", stall_cnt, 1);
        chk("st_err", en_err, 0);

        en(1, 1, 1); instr_IF = 32'h8C24_0008;
        tick();
        chk("ad_pc", PC, 32'h300C);
        chk("ad_instr", instr_IFID, 32'h8C24_0008);
        chk("ad_bubble_exmem", {RegWr_ExMem, MemtoReg_ExMem}, 0);
        chk("ad_regwr_idex", RegWr_IDEx, 1);
        chk("ad_cnt", stall_cnt, 1);

        // Flush taken
        flush_IFID = 1; pc_next = 32'h3010; instr_IF = 32'h1234_5678;
        tick();
        chk("fl_instr", instr_IFID, 0);
        chk("fl_pc4", pcplus4_IFID, 32'h3010);
        chk("fl_cnt", flush_cnt, 1);
        flush_IFID = 0; pc_next = 32'h3014; instr_IF = 32'hAAAA_5555;
        tick();
        chk("nf_instr", instr_IFID, 32'hAAAA_5555);
        // Flush while IF/ID held is ignored
        flush_IFID = 1; en(0, 0, 0);
        tick();
        chk("flh_instr", instr_IFID, 32'hAAAA_5555);
        chk("flh_pc4", pcplus4_IFID, 32'h3014);
        chk("flh_cnt", flush_cnt, 1);
        chk("flh_stall", stall_cnt, 2);
        flush_IFID = 0;

        // Clear beats a same-cycle stall event
        cnt_clr = 1;
        tick();
        chk("clr_stall", stall_cnt, 0);
        chk("clr_flush", flush_cnt, 0);
        cnt_clr = 0;
        for (int k = 0; k < 14; k++) tick();
        chk("sat_14", stall_cnt, 14);
        for (int k = 0; k < 6; k++) tick();
        chk("sat_20", stall_cnt, 15);
        en(1, 1, 1); cnt_clr = 1;
        tick();
        chk("sat_clr", stall_cnt, 0);
        cnt_clr = 0;

        // Enable mismatch
        en(1, 0, 1);
        tick();
        chk("err_set", en_err, 1);
        en(1, 1, 1);
        tick();
        chk("err_sticky", en_err, 1);
        en(1, 0, 1); cnt_clr = 1;
        tick();
        chk("err_clr_vs_set", en_err, 1);
        en(1, 1, 1);
        tick();
        chk("err_clr", en_err, 0);
        cnt_clr = 0;

        // PC+4 wraps
        pc_next = 32'hFFFF_FFFC;
        tick();
        pc_next = 32'h0;
        tick();
        chk("wrap_pc4", pcplus4_IFID, 0);

        // Async reset mid-stall
        en(0, 0, 0); alu_result_Ex = 32'h777; pc_next = 32'h4000;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pc", PC, 32'h3000);
        chk("ar_instr", instr_IFID, 0);
        chk("ar_cnt", stall_cnt, 0);
        chk("ar_alu", alu_ExMem, 0);
        chk("ar_err", en_err, 0);
        @(negedge clk);
        rst_n = 1'b1; en(1, 1, 1);
        tick();
        chk("rel_pc", PC, 32'h4000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
